// File: rtl/opr_result_reader_if.sv
// Handshake and buffer-port bundle between the result reader, the retire stage,
// and the operator result buffer.
interface opr_result_reader_if #(
    parameter int ADDRS_WIDTH = 4
);
    logic                   wren;
    logic [ADDRS_WIDTH-1:0] wraddrs;
    logic                   req_valid;
    logic [ADDRS_WIDTH-1:0] req_addrs;
    logic                   req_ready;
    logic                   rdenA;
    logic [ADDRS_WIDTH-1:0] rdaddrsA;
    logic [67:0]            rddataA;
    logic                   res_valid;
    logic                   res_ready;
    logic [63:0]            res_data;
    logic                   res_n;
    logic                   res_z;
    logic                   res_C;
    logic                   res_V;
    logic [ADDRS_WIDTH-1:0] res_addrs;
    logic                   res_err;

    modport slave (
        input  wren, wraddrs, req_valid, req_addrs, rddataA, res_ready,
        output req_ready, rdenA, rdaddrsA, res_valid, res_data,
               res_n, res_z, res_C, res_V, res_addrs, res_err
    );

    modport master (
        output wren, wraddrs, req_valid, req_addrs, rddataA, res_ready,
        input  req_ready, rdenA, rdaddrsA, res_valid, res_data,
               res_n, res_z, res_C, res_V, res_addrs, res_err
    );
endinterface

// File: rtl/opr_result_reader.sv
// Reads thread-indexed operator results once their slot has been written,
// unpacks {C,V,n,z,result} and returns them on a valid/ready handshake.
module opr_result_reader #(
    parameter int ADDRS_WIDTH = 4,
    parameter int TIMEOUT     = 255,
    parameter bit CONSUME     = 1'b1
) (
    input logic CLK,
    input logic RESET,
    opr_result_reader_if.slave bus
);
    localparam int         SLOTS       = 1 << ADDRS_WIDTH;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_OUT} state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [SLOTS-1:0]       validBits;
    logic [SLOTS-1:0]       validNext;
    logic [ADDRS_WIDTH-1:0] slotQ;
    logic [7:0]             waitCnt;
    logic [7:0]             waitCntInc;
    logic                   slotValid;
    logic                   acceptReq;
    logic                   issueRead;
    logic                   timeoutHit;
    logic                   retire;

    logic                   resValid;
    logic                   resErr;
    logic                   resC;
    logic                   resV;
    logic                   resN;
    logic                   resZ;
    logic [63:0]            resData;
    logic [ADDRS_WIDTH-1:0] resAddrs;

    assign slotValid  = validBits[slotQ];
    assign waitCntInc = (waitCnt == 8'hFF) ? waitCnt : waitCnt + 8'd1;

    always_comb begin
        stateNext  = state;
        acceptReq  = 1'b0;
        issueRead  = 1'b0;
        timeoutHit = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    acceptReq = 1'b1;
                    stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only a registered valid bit may launch the read, so a write
                // landing this cycle is picked up on the next one.
                if (slotValid) begin
                    issueRead = 1'b1;
                    stateNext = S_CAPT;
                end else if (TIMEOUT_EN && (waitCntInc == TIMEOUT_CNT)) begin
                    timeoutHit = 1'b1;
                    stateNext  = S_OUT;
                end
            end
            S_CAPT: stateNext = S_OUT;
            S_OUT: begin
                if (bus.res_ready) begin
                    retire    = 1'b1;
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Clear-on-read first, then the snooped write, so a same-edge rewrite survives.
    always_comb begin
        validNext = validBits;
        if (CONSUME && issueRead) validNext[slotQ] = 1'b0;
        if (bus.wren) validNext[bus.wraddrs] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            validBits <= '0;
            slotQ     <= '0;
            waitCnt   <= 8'd0;
        end else begin
            state     <= stateNext;
            validBits <= validNext;
            if (acceptReq) begin
                slotQ   <= bus.req_addrs;
                waitCnt <= 8'd0;
            end else if (state == S_WAIT && !slotValid) begin
                waitCnt <= waitCntInc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            resValid <= 1'b0;
            resErr   <= 1'b0;
            resC     <= 1'b0;
            resV     <= 1'b0;
            resN     <= 1'b0;
            resZ     <= 1'b0;
            resData  <= 64'd0;
            resAddrs <= '0;
        end else if (timeoutHit) begin
            resValid <= 1'b1;
            resErr   <= 1'b1;
            resC     <= 1'b0;
            resV     <= 1'b0;
            resN     <= 1'b0;
            resZ     <= 1'b0;
            resData  <= 64'd0;
            resAddrs <= slotQ;
        end else if (state == S_CAPT) begin
            resValid <= 1'b1;
            resErr   <= 1'b0;
            resC     <= bus.rddataA[67];
            resV     <= bus.rddataA[66];
            resN     <= bus.rddataA[65];
            resZ     <= bus.rddataA[64];
            resData  <= bus.rddataA[63:0];
            resAddrs <= slotQ;
        end else if (retire) begin
            resValid <= 1'b0;
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rdenA     = issueRead;
    assign bus.rdaddrsA  = issueRead ? slotQ : '0;
    assign bus.res_valid = resValid;
    assign bus.res_err   = resErr;
    assign bus.res_C     = resC;
    assign bus.res_V     = resV;
    assign bus.res_n     = resN;
    assign bus.res_z     = resZ;
    assign bus.res_data  = resData;
    assign bus.res_addrs = resAddrs;
endmodule

// File: tb/tb_opr_result_reader.sv
// Randomised and directed bench for opr_result_reader against a slot-level model
// of the result buffer (written flags + stored words).
module tb_opr_result_reader;
    localparam int TMO = 12;

    logic CLK = 1'b0;
    logic RESET;

    opr_result_reader_if #(.ADDRS_WIDTH(4)) bus ();

    opr_result_reader #(.ADDRS_WIDTH(4), .TIMEOUT(TMO), .CONSUME(1'b1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [67:0] mem [16];
    bit          written [16];
    int          nCmp = 0;
    int          nFail = 0;

    localparam logic [79:0] RESET_SNAP = {1'b1, 79'd0};

    // Operator buffer: synchronous read, data valid the cycle after rdenA.
    always @(posedge CLK) if (bus.rdenA) bus.rddataA <= mem[bus.rdaddrsA];

    function automatic logic [79:0] snap();
        return {bus.req_ready, bus.rdenA, bus.rdaddrsA, bus.res_valid, bus.res_err,
                bus.res_addrs, bus.res_C, bus.res_V, bus.res_n, bus.res_z, bus.res_data};
    endfunction

    function automatic logic [67:0] resVec();
        return {bus.res_C, bus.res_V, bus.res_n, bus.res_z, bus.res_data};
    endfunction

    function automatic logic [67:0] rnd68();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[67:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int s, input logic [67:0] d);
        mem[s] = d;
        bus.wren = 1'b1;
        bus.wraddrs = 4'(s);
        tick();
        bus.wren = 1'b0;
        written[s] = 1'b1;
    endtask

    task automatic do_req(input int s);
        bus.req_valid = 1'b1;
        bus.req_addrs = 4'(s);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_out();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) written[i] = 1'b0;
    endtask

    task automatic test_reset();
        bus.wren = 1'b0; bus.wraddrs = '0; bus.req_valid = 1'b0; bus.req_addrs = '0;
        bus.res_ready = 1'b0;
        RESET = 1'b1;
        tick(); tick();
        nCmp++; if (snap() !== RESET_SNAP) begin nFail++; $display("FAIL reset_outputs: got %h need %h", snap(), RESET_SNAP); end
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) written[i] = 1'b0;
        tick();
        nCmp++; if (snap() !== RESET_SNAP) begin nFail++; $display("FAIL reset_idle: got %h need %h", snap(), RESET_SNAP); end
    endtask

    task automatic test_basic();
        logic [67:0] d;
        d = {4'b1001, 64'h0};
        do_write(3, d);
        do_req(3);
        nCmp++; if ({bus.rdenA, bus.rdaddrsA, bus.req_ready} !== {1'b1, 4'd3, 1'b0}) begin nFail++; $display("FAIL basic_rden: got %b/%0d/%b need 1/3/0", bus.rdenA, bus.rdaddrsA, bus.req_ready); end
        tick();
        nCmp++; if ({bus.rdenA, bus.res_valid} !== 2'b00) begin nFail++; $display("FAIL basic_capt: got rden=%b vld=%b need 0/0", bus.rdenA, bus.res_valid); end
        tick();
        nCmp++; if (bus.res_valid !== 1'b1) begin nFail++; $display("FAIL basic_valid_T2: got %b need 1", bus.res_valid); end
        nCmp++; if ({bus.res_err, bus.res_addrs, resVec()} !== {1'b0, 4'd3, d}) begin nFail++; $display("FAIL basic_data: got %h need %h", {bus.res_err, bus.res_addrs, resVec()}, {1'b0, 4'd3, d}); end
        finish_out();
        written[3] = 1'b0;
        nCmp++; if ({bus.req_ready, bus.res_valid} !== 2'b10) begin nFail++; $display("FAIL basic_retire: got rdy=%b vld=%b need 1/0", bus.req_ready, bus.res_valid); end
    endtask

    task automatic test_late_write();
        logic [67:0] d;
        d = rnd68();
        do_req(5);
        for (int k = 0; k < 10; k++) begin
            nCmp++; if ({bus.rdenA, bus.res_valid} !== 2'b00) begin nFail++; $display("FAIL late_stall_%0d: got rden=%b vld=%b need 0/0", k, bus.rdenA, bus.res_valid); end
            tick();
        end
        mem[5] = d; bus.wren = 1'b1; bus.wraddrs = 4'd5;
        nCmp++; if (bus.rdenA !== 1'b0) begin nFail++; $display("FAIL late_same_cycle: got rden=%b need 0", bus.rdenA); end
        tick();
        bus.wren = 1'b0;
        nCmp++; if ({bus.rdenA, bus.rdaddrsA} !== {1'b1, 4'd5}) begin nFail++; $display("FAIL late_rden: got %b/%0d need 1/5", bus.rdenA, bus.rdaddrsA); end
        tick(); tick();
        nCmp++; if ({bus.res_valid, bus.res_err, bus.res_addrs, resVec()} !== {2'b10, 4'd5, d}) begin nFail++; $display("FAIL late_result: got %h need %h", {bus.res_valid, bus.res_err, bus.res_addrs, resVec()}, {2'b10, 4'd5, d}); end
        finish_out();
    endtask

    task automatic test_timeout_hold();
        logic [79:0] expOut;
        expOut = {1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 4'd0, 64'd0};
        do_req(7);
        for (int n = 1; n <= TMO; n++) begin
            tick();
            nCmp++; if ({bus.res_valid, bus.rdenA} !== {(n == TMO), 1'b0}) begin nFail++; $display("FAIL timeout_cycle_%0d: got vld=%b rden=%b need %b/0", n, bus.res_valid, bus.rdenA, (n == TMO)); end
        end
        nCmp++; if (snap() !== expOut) begin nFail++; $display("FAIL timeout_result: got %h need %h", snap(), expOut); end
        for (int k = 0; k < 5; k++) begin
            tick();
            nCmp++; if (snap() !== expOut) begin nFail++; $display("FAIL hold_%0d: got %h need %h", k, snap(), expOut); end
        end
        finish_out();
        nCmp++; if ({bus.req_ready, bus.res_valid} !== 2'b10) begin nFail++; $display("FAIL hold_release: got rdy=%b vld=%b need 1/0", bus.req_ready, bus.res_valid); end
    endtask

    task automatic test_consume();
        logic [67:0] d1, d2;
        d1 = rnd68();
        d2 = rnd68();
        do_write(2, d1);
        do_req(2);
        tick(); tick();
        nCmp++; if ({bus.res_valid, resVec()} !== {1'b1, d1}) begin nFail++; $display("FAIL consume_first: got %h need %h", {bus.res_valid, resVec()}, {1'b1, d1}); end
        finish_out();
        do_req(2);
        for (int k = 0; k < 4; k++) begin
            nCmp++; if ({bus.rdenA, bus.res_valid} !== 2'b00) begin nFail++; $display("FAIL consume_stall_%0d: got rden=%b vld=%b need 0/0", k, bus.rdenA, bus.res_valid); end
            tick();
        end
        mem[2] = d2; bus.wren = 1'b1; bus.wraddrs = 4'd2;
        tick();
        // wren stays high so the rewrite lands on the same edge as the read issue
        nCmp++; if ({bus.rdenA, bus.rdaddrsA} !== {1'b1, 4'd2}) begin nFail++; $display("FAIL consume_rden: got %b/%0d need 1/2", bus.rdenA, bus.rdaddrsA); end
        tick();
        bus.wren = 1'b0;
        tick();
        nCmp++; if ({bus.res_valid, resVec()} !== {1'b1, d2}) begin nFail++; $display("FAIL consume_second: got %h need %h", {bus.res_valid, resVec()}, {1'b1, d2}); end
        finish_out();
        do_req(2);
        nCmp++; if (bus.rdenA !== 1'b1) begin nFail++; $display("FAIL consume_set_wins: got rden=%b need 1", bus.rdenA); end
        tick(); tick();
        nCmp++; if ({bus.res_valid, bus.res_err, resVec()} !== {2'b10, d2}) begin nFail++; $display("FAIL consume_third: got %h need %h", {bus.res_valid, bus.res_err, resVec()}, {2'b10, d2}); end
        finish_out();
        written[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_write(9, rnd68());
        do_req(4);
        tick(); tick();
        do_reset();
        nCmp++; if (snap() !== RESET_SNAP) begin nFail++; $display("FAIL reset_in_wait: got %h need %h", snap(), RESET_SNAP); end
        do_req(9);
        for (int k = 0; k < 3; k++) begin
            nCmp++; if (bus.rdenA !== 1'b0) begin nFail++; $display("FAIL reset_scoreboard_%0d: got rden=%b need 0", k, bus.rdenA); end
            tick();
        end
        do_reset();
        do_write(1, rnd68());
        do_req(1);
        tick(); tick();
        nCmp++; if (bus.res_valid !== 1'b1) begin nFail++; $display("FAIL reset_pre_out: got vld=%b need 1", bus.res_valid); end
        do_reset();
        nCmp++; if (snap() !== RESET_SNAP) begin nFail++; $display("FAIL reset_in_out: got %h need %h", snap(), RESET_SNAP); end
    endtask

    task automatic test_random();
        int s, mode, dly, lat, expLat, o;
        bit ok, got, wrOther;
        logic [67:0] d, expVec;
        logic [72:0] expRes;
        for (int t = 0; t < 30; t++) begin
            s = $urandom_range(0, 15);
            d = rnd68();
            mode = $urandom_range(0, 2);
            dly = $urandom_range(0, TMO - 3);
            if (written[s]) mode = 0;
            if (mode == 0 && (!written[s] || $urandom_range(0, 1) == 1)) do_write(s, d);
            ok = written[s];
            do_req(s);
            got = 1'b0;
            lat = 0;
            for (int c = 0; c < TMO + 6 && !got; c++) begin
                nCmp++; if (bus.rdenA && !ok) begin nFail++; $display("FAIL rand_rden_unwritten: t=%0d slot=%0d got rden=1 need 0", t, s); end
                if (bus.res_valid) begin
                    got = 1'b1;
                    lat = c;
                end else begin
                    wrOther = 1'b0;
                    o = (s + $urandom_range(1, 15)) % 16;
                    if (mode == 1 && c == dly) begin
                        mem[s] = d; bus.wren = 1'b1; bus.wraddrs = 4'(s);
                    end else if ($urandom_range(0, 3) == 0) begin
                        mem[o] = rnd68(); bus.wren = 1'b1; bus.wraddrs = 4'(o); wrOther = 1'b1;
                    end
                    tick();
                    bus.wren = 1'b0;
                    if (mode == 1 && c == dly) ok = 1'b1;
                    if (wrOther) written[o] = 1'b1;
                end
            end
            nCmp++;
            if (!got) begin
                nFail++; $display("FAIL rand_no_response: t=%0d slot=%0d got no res_valid need one", t, s);
                do_reset();
            end else begin
                expLat = (mode == 0) ? 2 : (mode == 1) ? dly + 3 : TMO;
                expVec = (mode == 2) ? 68'd0 : mem[s];
                expRes = {(mode == 2), 4'(s), expVec};
                nCmp++; if (lat !== expLat) begin nFail++; $display("FAIL rand_latency: t=%0d got %0d need %0d", t, lat, expLat); end
                nCmp++; if ({bus.res_err, bus.res_addrs, resVec()} !== expRes) begin nFail++; $display("FAIL rand_result: t=%0d got %h need %h", t, {bus.res_err, bus.res_addrs, resVec()}, expRes); end
                for (int h = $urandom_range(0, 3); h > 0; h--) begin
                    tick();
                    nCmp++; if ({bus.res_valid, bus.req_ready, bus.res_err, bus.res_addrs, resVec()} !== {2'b10, expRes}) begin nFail++; $display("FAIL rand_hold: t=%0d got %h need %h", t, {bus.res_valid, bus.req_ready, bus.res_err, bus.res_addrs, resVec()}, {2'b10, expRes}); end
                end
                finish_out();
                nCmp++; if ({bus.req_ready, bus.res_valid} !== 2'b10) begin nFail++; $display("FAIL rand_retire: t=%0d got rdy=%b vld=%b need 1/0", t, bus.req_ready, bus.res_valid); end
                if (mode != 2) written[s] = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_write();
        test_timeout_hold();
        test_consume();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
